// File: rtl/chrow_loader_pkg.sv
// Text-mode geometry and loader state encoding shared by the chrowbuf writer
// and the character renderer.
`timescale 1ns/1ps
package chrow_loader_pkg;

  localparam int COLS      = 100;  // character cells per text row
  localparam int ROWS      = 38;   // text rows per frame
  localparam int VADDR_W   = 13;   // text memory word address width
  localparam int BANK_SIZE = 128;  // chrowbuf entries per bank
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;

  localparam int ROW_W  = 6;
  localparam int CELL_W = 16;
  localparam int COL_W  = $clog2(BANK_SIZE);
  localparam int WADDR_W = COL_W + 1;

  // Cell layout: attribute in the high byte, character code in the low byte.
  localparam int ATTR_MSB = 15;
  localparam int ATTR_LSB = 8;
  localparam int CODE_MSB = 7;
  localparam int CODE_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // First text memory word of a row; wraps modulo the address space.
  function automatic logic [VADDR_W-1:0] row_base(input logic [ROW_W-1:0] r);
    return VADDR_W'(r) * VADDR_W'(COLS);
  endfunction

endpackage

// File: rtl/chrow_loader_if.sv
// Control, text memory and chrowbuf write signals of the row loader.
`timescale 1ns/1ps
interface chrow_loader_if;
  import chrow_loader_pkg::*;

  // start: one-cycle pulse, taken only when the loader is idle, otherwise
  //   answered by an overrun pulse one cycle later.
  // vram: vram_req and vram_addr stay stable until vram_ack; vram_data is
  //   valid in the ack cycle; an ack while vram_req is low is ignored.
  // chrowbuf: chrowbuf_wr is an active-low one-cycle write strobe.
  logic                 start;
  logic [ROW_W-1:0]     row;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  logic                 vram_req;
  logic [VADDR_W-1:0]   vram_addr;
  logic                 vram_ack;
  logic [CELL_W-1:0]    vram_data;
  logic                 chrowbuf_wr;
  logic [WADDR_W-1:0]   chrowbuf_wr_addr;
  logic [CELL_W-1:0]    chrowbuf_wr_data;

  modport master (
    input  start, row, vram_ack, vram_data,
    output busy, done, overrun, vram_req, vram_addr,
           chrowbuf_wr, chrowbuf_wr_addr, chrowbuf_wr_data
  );

  modport slave (
    output start, row, vram_ack, vram_data,
    input  busy, done, overrun, vram_req, vram_addr,
           chrowbuf_wr, chrowbuf_wr_addr, chrowbuf_wr_data
  );

endinterface

// File: rtl/chrow_loader.sv
// Fetches one text row of attribute/code cells from text memory and writes
// them into the chrowbuf bank selected by the row's parity.
`timescale 1ns/1ps
module chrow_loader
  import chrow_loader_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  chrow_loader_if.master bus,
  output state_t         dbg_state
);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(ROWS);

  state_t             state;
  state_t             state_n;
  logic               accept;
  logic               reject;
  logic [VADDR_W-1:0] base;
  logic [COL_W-1:0]   col;
  logic               bank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.row < ROW_LIMIT) begin
            accept  = 1'b1;
            state_n = ST_REQ;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_REQ: begin
        reject = bus.start;
        if (bus.vram_ack && bus.vram_req) state_n = ST_WR;
      end
      ST_WR: begin
        reject  = bus.start;
        state_n = (col == LAST_COL) ? ST_FIN : ST_REQ;
      end
      ST_FIN: begin
        reject  = bus.start;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Every output is a flop loaded from the next state, so the request and
  // write strobe line up with the REQ and WR cycles they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base                 <= '0;
      col                  <= '0;
      bank                 <= 1'b0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.overrun          <= 1'b0;
      bus.vram_req         <= 1'b0;
      bus.vram_addr        <= '0;
      bus.chrowbuf_wr      <= 1'b1;
      bus.chrowbuf_wr_addr <= '0;
      bus.chrowbuf_wr_data <= '0;
    end else begin
      bus.done        <= (state == ST_FIN);
      bus.overrun     <= reject;
      bus.vram_req    <= (state_n == ST_REQ);
      bus.chrowbuf_wr <= (state_n != ST_WR);

      if (accept) begin
        base          <= row_base(bus.row);
        col           <= '0;
        bank          <= bus.row[0];
        bus.vram_addr <= row_base(bus.row);
        bus.busy      <= 1'b1;
      end

      if (state == ST_REQ && state_n == ST_WR) begin
        bus.chrowbuf_wr_addr <= {bank, col};
        bus.chrowbuf_wr_data <= bus.vram_data;
      end

      if (state == ST_WR && state_n == ST_REQ) begin
        col           <= col + COL_W'(1);
        bus.vram_addr <= base + VADDR_W'(col) + VADDR_W'(1);
      end

      // busy and done swap in the cycle after FIN retires.
      if (state == ST_FIN) bus.busy <= 1'b0;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_chrow_loader.sv
// Directed and randomized checks of chrow_loader against a text memory model
// and a per-row expected queue of reads and chrowbuf writes.
`timescale 1ns/1ps
module tb_chrow_loader;
  import chrow_loader_pkg::*;

  localparam int MAX_LOG = 4096;
  localparam int EXP_W   = VADDR_W + WADDR_W + CELL_W;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     cyc = 0;

  chrow_loader_if bus();

  chrow_loader dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial forever #12.5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- text memory model and monitors ----------------
  logic [CELL_W-1:0]  vmem [0:8191];
  int                 max_delay  = 0;
  bit                 idle_noise = 1'b0;

  bit                 in_req = 1'b0;
  bit                 prev_wr_low = 1'b0;
  logic [VADDR_W-1:0] req_addr;
  int                 cur_delay = 0;
  int                 wait_n = 0;
  int                 req_cnt = 0, wr_cnt = 0, busy_cnt = 0, done_cnt = 0, ovr_cnt = 0;
  int                 stab_err = 0, dbl_err = 0, last_done_cyc = 0, last_ovr_cyc = 0;
  logic [VADDR_W-1:0] req_log     [MAX_LOG];
  logic [WADDR_W-1:0] wr_addr_log [MAX_LOG];
  logic [CELL_W-1:0]  wr_data_log [MAX_LOG];

  initial begin
    bus.vram_ack  = 1'b0;
    bus.vram_data = '0;
    forever begin
      @(negedge clk);
      if (bus.vram_req === 1'b1) begin
        if (!in_req) begin
          in_req    = 1'b1;
          req_addr  = bus.vram_addr;
          wait_n    = 0;
          cur_delay = $urandom_range(max_delay, 0);
          if (req_cnt < MAX_LOG) req_log[req_cnt] = bus.vram_addr;
          req_cnt++;
        end else if (bus.vram_addr !== req_addr) begin
          stab_err++;
        end
        if (wait_n >= cur_delay) begin
          bus.vram_ack  = 1'b1;
          bus.vram_data = vmem[bus.vram_addr];
        end else begin
          bus.vram_ack = 1'b0;
          wait_n++;
        end
      end else begin
        in_req       = 1'b0;
        bus.vram_ack = idle_noise ? 1'($urandom_range(1, 0)) : 1'b0;
      end

      if (bus.chrowbuf_wr === 1'b0) begin
        if (prev_wr_low) dbl_err++;
        if (wr_cnt < MAX_LOG) begin
          wr_addr_log[wr_cnt] = bus.chrowbuf_wr_addr;
          wr_data_log[wr_cnt] = bus.chrowbuf_wr_data;
        end
        wr_cnt++;
      end
      prev_wr_low = (bus.chrowbuf_wr === 1'b0);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (bus.overrun === 1'b1) begin
        ovr_cnt++;
        last_ovr_cyc = cyc;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int s_req, s_wr, s_busy, s_done, s_ovr, s_stab, s_dbl, c0, t_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int r);
    @(negedge clk); #1;
    bus.start = 1'b1;
    bus.row   = 6'(r);
    t_pulse   = cyc;
    @(negedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic begin_load(input int r);
    int va;
    exp_q.delete();
    for (int c = 0; c < COLS; c++) begin
      va = (r * COLS + c) % 8192;
      exp_q.push_back({13'(va), 8'((r % 2) * BANK_SIZE + c), vmem[va]});
    end
    s_req  = req_cnt;  s_wr  = wr_cnt;  s_busy = busy_cnt; s_done = done_cnt;
    s_ovr  = ovr_cnt;  s_stab = stab_err; s_dbl = dbl_err;
    pulse_start(r);
    c0 = t_pulse;
  endtask

  task automatic finish_load(input bit zero_wait, input int budget);
    int n;
    logic [EXP_W-1:0] e;
    n = 0;
    while (done_cnt == s_done && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("load_timeout", 32'(done_cnt != s_done), 32'd1);
    @(negedge clk); #1;
    check("done_pulses", done_cnt - s_done, 1);
    check("req_count", req_cnt - s_req, COLS);
    check("wr_count", wr_cnt - s_wr, COLS);
    check("req_stable", stab_err - s_stab, 0);
    check("wr_strobe_double", dbl_err - s_dbl, 0);
    for (int i = 0; i < COLS; i++) begin
      e = exp_q.pop_front();
      check("vram_addr", 32'(req_log[s_req + i]), 32'(e[EXP_W-1 -: VADDR_W]));
      check("wr_addr", 32'(wr_addr_log[s_wr + i]), 32'(e[CELL_W +: WADDR_W]));
      check("wr_data", 32'(wr_data_log[s_wr + i]), 32'(e[CELL_W-1:0]));
    end
    if (zero_wait) begin
      check("done_cycle", last_done_cyc - c0, 2 * COLS + 2);
      check("busy_cycles", busy_cnt - s_busy, 2 * COLS + 1);
    end
    check("busy_after", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int so;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.row   = '0;
    for (int i = 0; i < 8192; i++) vmem[i] = 16'(i) ^ 16'hA5A5;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_vram_req", 32'(bus.vram_req), 32'd0);
    check("rst_vram_addr", 32'(bus.vram_addr), 32'd0);
    check("rst_wr", 32'(bus.chrowbuf_wr), 32'd1);
    check("rst_wr_addr", 32'(bus.chrowbuf_wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.chrowbuf_wr_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // basic row 0 and odd row 5, zero-wait ack
    begin_load(0);
    finish_load(1'b1, 400);
    begin_load(5);
    finish_load(1'b1, 400);

    // random wait states, random data, stray acks while idle or writing
    for (int i = 0; i < 8192; i++) vmem[i] = 16'($urandom);
    max_delay  = 5;
    idle_noise = 1'b1;
    repeat (2) begin
      begin_load($urandom_range(ROWS - 1, 0));
      finish_load(1'b0, 2000);
    end
    max_delay  = 0;
    idle_noise = 1'b0;

    // start during a load and start in the FIN cycle are both rejected
    begin_load(2);
    repeat (50) @(negedge clk);
    #1;
    pulse_start(7);
    @(negedge clk); #1;
    check("ovr_midload_cnt", ovr_cnt - s_ovr, 1);
    check("ovr_midload_cycle", last_ovr_cyc - t_pulse, 1);
    n = 0;
    while (cyc - c0 < 2 * COLS && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    pulse_start(3);
    check("ovr_fin_cycle", t_pulse - c0, 2 * COLS + 1);
    check("ovr_fin_pulse", last_ovr_cyc - t_pulse, 1);
    check("ovr_total", ovr_cnt - s_ovr, 2);
    finish_load(1'b1, 400);

    // out-of-range rows while idle
    for (int r = ROWS; r < 64; r += 25) begin
      so = ovr_cnt;
      s_req = req_cnt;
      s_busy = busy_cnt;
      pulse_start(r);
      repeat (5) @(negedge clk);
      #1;
      check("ovr_badrow_cnt", ovr_cnt - so, 1);
      check("ovr_badrow_cycle", last_ovr_cyc - t_pulse, 1);
      check("badrow_no_req", req_cnt - s_req, 0);
      check("badrow_no_busy", busy_cnt - s_busy, 0);
      check("badrow_state", 32'(dbg_state), 32'(ST_IDLE));
    end

    // asynchronous reset while column 40 is being written
    begin_load(9);
    n = 0;
    while (wr_cnt - s_wr < 41 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check("arst_reached_col40", wr_cnt - s_wr, 41);
    check("arst_wr_before", 32'(bus.chrowbuf_wr), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check("arst_vram_req", 32'(bus.vram_req), 32'd0);
    check("arst_wr", 32'(bus.chrowbuf_wr), 32'd1);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk); #1;
    rst = 1'b0;
    begin_load(1);
    finish_load(1'b1, 400);

    // last text row, bank 1
    begin_load(ROWS - 1);
    finish_load(1'b1, 400);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/chrow_loader.md
Name: chrow_loader

Overview:
- Writer side of the character attribute/code row buffer (chrowbuf).
- Before each text row is displayed, it fetches that row's character cells (attribute + code, 16 bits each) from text memory over a req/ack port.
- It writes the cells into one bank of the double-banked chrowbuf; the character renderer reads the other bank.
- A display-timing controller issues start one text row ahead of display.

Parameters:
- COLS, 100, character cells per text row (800 px / 8).
- ROWS, 38, text rows per frame (600 px / 16, rounded up).
- VADDR_W, 13, text memory address width (ROWS*COLS <= 2^VADDR_W).
- BANK_SIZE, 128, chrowbuf entries per bank (power of 2, >= COLS).

Ports:
- clk  in  1  40 MHz pixel clock from the global buffer
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse: load text row `row`
- row  in  6  text row index to load, sampled when start=1
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses
- done  out  1  one-cycle pulse when a row load completes
- overrun  out  1  one-cycle pulse when start is rejected
- vram_req  out  1  text memory read request, active-high
- vram_addr  out  VADDR_W  text memory word address
- vram_ack  in  1  request accepted; vram_data is valid in the same cycle
- vram_data  in  16  attribute/code word
- chrowbuf_wr  out  1  chrowbuf write strobe, active-low, matching chrowbuf's existing port polarity
- chrowbuf_wr_addr  out  8  {bank, col[6:0]}
- chrowbuf_wr_data  out  16  cell data

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-load):
  - State returns to IDLE.
  - busy=0, done=0, overrun=0, vram_req=0, vram_addr=0.
  - chrowbuf_wr=1 (no write), chrowbuf_wr_addr=0, chrowbuf_wr_data=0.
  - A partially loaded bank is left as is; it is not cleared.
- All outputs are registered.
- States:
  - IDLE:
    - start=1 and row<ROWS: latch row, col=0, base=row*COLS (constant multiply is acceptable), bank=row[0]; go to REQ.
    - start=1 and row>=ROWS: ignored; overrun pulses next cycle.
  - REQ:
    - vram_req=1, vram_addr=base+col. Both are held stable until vram_ack.
    - On vram_ack: capture vram_data; drop vram_req; go to WR.
    - vram_ack while vram_req=0 is ignored.
  - WR (exactly one cycle):
    - chrowbuf_wr=0, chrowbuf_wr_addr={bank, col[6:0]}, chrowbuf_wr_data=captured word.
    - If col==COLS-1, go to FIN. Otherwise col+1, go to REQ.
  - FIN (exactly one cycle): done=1, busy=0 in the same cycle; go to IDLE.
- Throughput with zero-wait ack (ack in the first REQ cycle): 2 cycles per cell.
  - A full row takes 2*COLS+2 = 202 cycles from start to done.
  - Budget is 16 scanlines, so there is large slack.
- start while not IDLE: ignored; overrun pulses one cycle later. The load in progress is unaffected.
- start in the same cycle as FIN: treated as busy, so rejected with overrun.
- Addresses: vram_addr wraps modulo 2^VADDR_W (cannot occur with the defaults). col never exceeds COLS-1; chrowbuf addresses COLS..BANK_SIZE-1 are never written.
- chrowbuf_wr is low only in WR cycles; it is never low for two consecutive cycles.

Decomposition:
- Shared header text_geom.vh, alongside timing.vh, holds:
  - COLS, ROWS, BANK_SIZE, VADDR_W.
  - CHAR_W=8, CHAR_H=16.
  - Cell field positions: attribute [15:8], code [7:0].
- The renderer uses the same header for bank select (vcount[4]) and cell layout.
- No sub-module: a single FSM plus counters.

Test Plan:
- Basic load: reset, then start with row=0; zero-wait ack; text memory model returns addr^16'hA5A5.
  - 100 writes to chrowbuf addresses 0..99 with the matching data.
  - done at cycle 202; busy high during cycles 1..201.
- Odd row with bank select: start row=5.
  - vram_addr runs 500..599.
  - chrowbuf_wr_addr runs 128..227.
  - Bank 0 is untouched.
- Wait states: random 0–5 cycle ack delay.
  - vram_req and vram_addr stay stable until ack.
  - Data, order and count are all correct.
  - Exactly 100 active-low write strobes.
- Overrun:
  - start during a load → overrun pulse; the load completes unchanged.
  - start with row=38 in IDLE → overrun pulse, no vram_req.
- Async reset mid-load: assert rst at col=40 between clock edges.
  - vram_req=0 and chrowbuf_wr=1 immediately, without waiting for a clock edge.
  - After release, a new start row=1 loads cleanly.
- Last row boundary: start row=37.
  - vram_addr runs 3700..3799.
  - Bank 1.
  - done pulse is a single cycle.
